// File: rtl/led7seg_scan.sv
// -----------------------------------------------------------------------------
// led7seg_scan
//
// Multiplexed NDIG-digit hexadecimal 7-segment display driver. A value
// register holds one nibble per digit. A prescaler steps a digit index so
// that each digit is lit for PRESCALE clock cycles. The selected nibble is
// decoded onto a shared, active-high segment bus next to a one-hot digit
// enable. Leading zeros can optionally be blanked. A one-cycle frame strobe
// marks the start of every scan.
//
// Parameters
//   NDIG      number of digits, 1..8
//   PRESCALE  clock cycles each digit stays lit, >= 1
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous, active-high reset
//   load      in   capture din into the value register
//   din       in   [4*NDIG] nibble i is digit i, digit 0 is rightmost
//   blank_lz  in   enable leading-zero blanking (sampled every cycle)
//   seg       out  [7] segments {A,B,C,D,E,F,G}, active-high, registered
//   an        out  [NDIG] one-hot digit enable, active-high, registered
//   frame     out  one-cycle pulse on the first output of each new scan
//   dp_in     in   [NDIG] per-digit decimal points     (LED7SEG_SCAN_DP_EN)
//   dp        out  decimal point of the lit digit       (LED7SEG_SCAN_DP_EN)
//
// Configuration
//   LED7SEG_SCAN_DP_EN  when defined, adds the decimal-point ports and logic.
//                       When undefined, neither port nor any dp logic exists.
// -----------------------------------------------------------------------------
module led7seg_scan #(
   parameter int NDIG     = 4,
   parameter int PRESCALE = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [4*NDIG-1:0] din,
   input  logic              blank_lz,
   output logic [6:0]        seg,
   output logic [NDIG-1:0]   an,
   output logic              frame
`ifdef LED7SEG_SCAN_DP_EN
   ,
   input  logic [NDIG-1:0]   dp_in,
   output logic              dp
`endif
);

   // Counter widths are kept at least one bit so NDIG=1 and PRESCALE=1
   // still produce legal vectors.
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

   // --------------------------------------------------------------------------
   // Hex to 7-segment decode, segments ordered {A,B,C,D,E,F,G}.
   // --------------------------------------------------------------------------
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h7E;
         4'h1:    s = 7'h30;
         4'h2:    s = 7'h6D;
         4'h3:    s = 7'h79;
         4'h4:    s = 7'h33;
         4'h5:    s = 7'h5B;
         4'h6:    s = 7'h5F;
         4'h7:    s = 7'h70;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h7B;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h1F;
         4'hC:    s = 7'h4E;
         4'hD:    s = 7'h3D;
         4'hE:    s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [4*NDIG-1:0] val_q,   val_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              wrap_q,  wrap_d;   // this edge wrapped idx back to 0
   logic [6:0]        seg_q,   seg_d;
   logic [NDIG-1:0]   an_q,    an_d;
   logic              frame_q, frame_d;
`ifdef LED7SEG_SCAN_DP_EN
   logic              dp_q,    dp_d;
`endif

   // Combinational helpers
   logic              presc_tick;        // prescaler at its terminal count
   logic [NDIG-1:0]   upper_zero;        // nibbles NDIG-1..i are all zero
   logic [3:0]        cur_nib;           // nibble of the selected digit
   logic              cur_upper_zero;    // upper_zero of the selected digit
   logic              cur_blank;         // selected digit is blanked

   // --------------------------------------------------------------------------
   // Value register, prescaler and digit index next-state.
   // A load never touches the scan position, so a load and a wrap on the
   // same edge both take effect.
   // --------------------------------------------------------------------------
   always_comb begin : scan_next
      val_d      = load ? din : val_q;

      presc_tick = (presc_q == PRE_LAST);
      wrap_d     = presc_tick && (idx_q == IDX_LAST);

      presc_d    = presc_tick ? '0 : presc_q + PRE_ONE;

      if (!presc_tick) begin
         idx_d = idx_q;
      end else if (wrap_d) begin
         idx_d = '0;
      end else begin
         idx_d = idx_q + IDX_ONE;
      end
   end

   // --------------------------------------------------------------------------
   // Leading-zero map: walk from the most significant nibble downwards and
   // record, for every position, whether everything above and including it
   // is zero.
   // --------------------------------------------------------------------------
   always_comb begin : lz_map
      logic all_zero;
      // NOTE: blocking assignments in combinational logic let all_zero act
      // as a running value through the loop; every output gets a default
      // first so no latch can be inferred.
      upper_zero = '0;
      all_zero   = 1'b1;
      for (int i = NDIG - 1; i >= 0; i--) begin
         all_zero      = all_zero && (val_q[4*i +: 4] == 4'h0);
         upper_zero[i] = all_zero;
      end
   end

   // --------------------------------------------------------------------------
   // Digit selection. A compare loop is used instead of a variable part-select
   // so that index values above NDIG-1 (non power-of-two NDIG) select nothing
   // rather than reading past the vector.
   // --------------------------------------------------------------------------
   always_comb begin : digit_select
      cur_nib        = 4'h0;
      cur_upper_zero = 1'b0;
      an_d           = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib        = val_q[4*i +: 4];
            cur_upper_zero = upper_zero[i];
            an_d[i]        = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output next-state. Digit 0 is never blanked so a zero value still shows
   // a single '0'. The digit enable stays on for a blanked digit; only its
   // segments are dark.
   // --------------------------------------------------------------------------
   always_comb begin : output_next
      cur_blank = blank_lz && (idx_q != '0) && cur_upper_zero;
      seg_d     = cur_blank ? 7'h00 : hex_to_seg(cur_nib);
      // frame is delayed one edge behind the wrap so it lines up with the
      // first output of digit 0.
      frame_d   = wrap_q;
   end

`ifdef LED7SEG_SCAN_DP_EN
   always_comb begin : dp_next
      dp_d = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == IDX_W'(i)) begin
            dp_d = dp_in[i];
         end
      end
      if (cur_blank) begin
         dp_d = 1'b0;
      end
   end
`endif

   // --------------------------------------------------------------------------
   // Registers. Reset is synchronous and wins over load.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin : regs
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         val_q   <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         seg_q   <= 7'h00;
         an_q    <= '0;
         frame_q <= 1'b0;
      end else begin
         val_q   <= val_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         frame_q <= frame_d;
      end
   end

`ifdef LED7SEG_SCAN_DP_EN
   always_ff @(posedge clk) begin : dp_reg
      if (rst) begin
         dp_q <= 1'b0;
      end else begin
         dp_q <= dp_d;
      end
   end

   assign dp = dp_q;
`endif

   assign seg   = seg_q;
   assign an    = an_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// -----------------------------------------------------------------------------
// tb_led7seg_scan
//
// Directed bench for led7seg_scan. dut0 uses NDIG=4, PRESCALE=2; dut1 uses
// NDIG=1, PRESCALE=1 for the full decode table. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point, well away
// from the next active edge. Edge numbers in comments count non-reset edges
// after the most recent reset release, starting at 1.
// Decimal-point scenarios build only when LED7SEG_SCAN_DP_EN is defined.
// -----------------------------------------------------------------------------
module tb_led7seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] din;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame;

   logic        load1;
   logic [3:0]  din1;
   logic        blank1;
   logic [6:0]  seg1;
   logic [0:0]  an1;
   logic        frame1;

`ifdef LED7SEG_SCAN_DP_EN
   logic [3:0]  dp_in;
   logic        dp;
   logic [0:0]  dp_in1;
   logic        dp1;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   led7seg_scan #(.NDIG(4), .PRESCALE(2)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .din      (din),
      .blank_lz (blank_lz),
      .seg      (seg),
      .an       (an),
      .frame    (frame)
`ifdef LED7SEG_SCAN_DP_EN
      ,
      .dp_in    (dp_in),
      .dp       (dp)
`endif
   );

   led7seg_scan #(.NDIG(1), .PRESCALE(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .load     (load1),
      .din      (din1),
      .blank_lz (blank1),
      .seg      (seg1),
      .an       (an1),
      .frame    (frame1)
`ifdef LED7SEG_SCAN_DP_EN
      ,
      .dp_in    (dp_in1),
      .dp       (dp1)
`endif
   );

   // Decode table written out by hand from the segment map.
   localparam logic [6:0] DEC [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   // {an, seg, frame} after edges 2..11, din=1234 loaded at edge 1.
   localparam logic [11:0] SCAN_EXP [10] = '{
      {4'b0001, 7'h33, 1'b0},
      {4'b0010, 7'h79, 1'b0},
      {4'b0010, 7'h79, 1'b0},
      {4'b0100, 7'h6D, 1'b0},
      {4'b0100, 7'h6D, 1'b0},
      {4'b1000, 7'h30, 1'b0},
      {4'b1000, 7'h30, 1'b0},
      {4'b0001, 7'h33, 1'b1},
      {4'b0001, 7'h33, 1'b0},
      {4'b0010, 7'h79, 1'b0}
   };

   // {an, seg, frame} after edges 2..19: din=0050 with blanking, din=0 loaded
   // at edge 9, blanking switched off before edge 17.
   localparam logic [11:0] BLZ_EXP [18] = '{
      {4'b0001, 7'h7E, 1'b0},
      {4'b0010, 7'h5B, 1'b0},
      {4'b0010, 7'h5B, 1'b0},
      {4'b0100, 7'h00, 1'b0},
      {4'b0100, 7'h00, 1'b0},
      {4'b1000, 7'h00, 1'b0},
      {4'b1000, 7'h00, 1'b0},
      {4'b0001, 7'h7E, 1'b1},
      {4'b0001, 7'h7E, 1'b0},
      {4'b0010, 7'h00, 1'b0},
      {4'b0010, 7'h00, 1'b0},
      {4'b0100, 7'h00, 1'b0},
      {4'b0100, 7'h00, 1'b0},
      {4'b1000, 7'h00, 1'b0},
      {4'b1000, 7'h00, 1'b0},
      {4'b0001, 7'h7E, 1'b1},
      {4'b0001, 7'h7E, 1'b0},
      {4'b0010, 7'h7E, 1'b0}
   };

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two reset edges; the next tick() is edge 1.
   task automatic do_reset();
      rst   = 1'b1;
      load  = 1'b0;
      load1 = 1'b0;
      tick();
      tick();
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      load     = 1'b1;
      din      = 16'hFFFF;
      blank_lz = 1'b0;
      load1    = 1'b0;
      din1     = 4'h0;
      blank1   = 1'b0;
`ifdef LED7SEG_SCAN_DP_EN
      dp_in    = 4'b1111;
      dp_in1   = 1'b0;
`endif
      for (int i = 0; i < 3; i++) tick();
      load = 1'b0;
      vec_cnt++;
      if ({an, seg, frame} !== {4'b0000, 7'h00, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_hold: an=%b seg=%h frame=%b, expected an=0000 seg=00 frame=0",
                  an, seg, frame);
      end
`ifdef LED7SEG_SCAN_DP_EN
      vec_cnt++;
      if (dp !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_dp: dp=%b, expected 0", dp);
      end
      dp_in = 4'b0000;
`endif
      // load was high during reset: val must still be zero afterwards.
      rst = 1'b0;
      tick();
      vec_cnt++;
      if ({an, seg, frame} !== {4'b0001, 7'h7E, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_release: an=%b seg=%h frame=%b, expected an=0001 seg=7e frame=0",
                  an, seg, frame);
      end
   endtask

   task automatic test_scan();
      do_reset();
      din      = 16'h1234;
      blank_lz = 1'b0;
      load     = 1'b1;
      tick();                                   // edge 1
      load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         vec_cnt++;
         if ({an, seg, frame} !== SCAN_EXP[i]) begin
            err_cnt++;
            $display("FAIL scan[%0d]: an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b",
                     i, an, seg, frame, SCAN_EXP[i][11:8], SCAN_EXP[i][7:1], SCAN_EXP[i][0]);
         end
      end
   endtask

   task automatic test_decode();
      do_reset();
      blank1 = 1'b0;
      tick();                                   // edge 1: no wrap seen yet
      vec_cnt++;
      if ({an1, seg1, frame1} !== {1'b1, 7'h7E, 1'b0}) begin
         err_cnt++;
         $display("FAIL decode_first: an=%b seg=%h frame=%b, expected an=1 seg=7e frame=0",
                  an1, seg1, frame1);
      end
      for (int v = 0; v < 16; v++) begin
         din1  = 4'(v);
         load1 = 1'b1;
         tick();
         load1 = 1'b0;
         tick();
         vec_cnt++;
         if ({an1, seg1, frame1} !== {1'b1, DEC[v], 1'b1}) begin
            err_cnt++;
            $display("FAIL decode[%0h]: an=%b seg=%h frame=%b, expected an=1 seg=%h frame=1",
                     v, an1, seg1, frame1, DEC[v]);
         end
      end
      // Single digit is digit 0 and is never blanked.
      blank1 = 1'b1;
      din1   = 4'h0;
      load1  = 1'b1;
      tick();
      load1 = 1'b0;
      tick();
      vec_cnt++;
      if (seg1 !== 7'h7E) begin
         err_cnt++;
         $display("FAIL decode_blank_digit0: seg=%h, expected 7e", seg1);
      end
      blank1 = 1'b0;
   endtask

   task automatic test_blanking();
      do_reset();
      din      = 16'h0050;
      blank_lz = 1'b1;
      load     = 1'b1;
      tick();                                   // edge 1
      load = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i == 7) begin
            din  = 16'h0000;
            load = 1'b1;
         end
         if (i == 15) blank_lz = 1'b0;
         tick();
         load = 1'b0;
         vec_cnt++;
         if ({an, seg, frame} !== BLZ_EXP[i]) begin
            err_cnt++;
            $display("FAIL blank[%0d]: an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b",
                     i, an, seg, frame, BLZ_EXP[i][11:8], BLZ_EXP[i][7:1], BLZ_EXP[i][0]);
         end
      end
   endtask

   task automatic test_midscan();
      do_reset();
      din      = 16'h1234;
      blank_lz = 1'b0;
      load     = 1'b1;
      tick();                                   // edge 1
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick();      // edges 2..4, idx now 2
      din  = 16'hABCD;
      load = 1'b1;
      tick();                                   // edge 5: still old value
      load = 1'b0;
      vec_cnt++;
      if ({an, seg} !== {4'b0100, 7'h6D}) begin
         err_cnt++;
         $display("FAIL midload_old: an=%b seg=%h, expected an=0100 seg=6d", an, seg);
      end
      tick();                                   // edge 6: nibble 2 = B
      vec_cnt++;
      if ({an, seg} !== {4'b0100, 7'h1F}) begin
         err_cnt++;
         $display("FAIL midload_new: an=%b seg=%h, expected an=0100 seg=1f", an, seg);
      end
      tick();                                   // edge 7: dwell kept, digit 3 = A
      vec_cnt++;
      if ({an, seg} !== {4'b1000, 7'h77}) begin
         err_cnt++;
         $display("FAIL midload_dwell: an=%b seg=%h, expected an=1000 seg=77", an, seg);
      end
      rst = 1'b1;                               // idx=3
      tick();
      rst = 1'b0;
      vec_cnt++;
      if ({an, seg, frame} !== {4'b0000, 7'h00, 1'b0}) begin
         err_cnt++;
         $display("FAIL midrst_hold: an=%b seg=%h frame=%b, expected an=0000 seg=00 frame=0",
                  an, seg, frame);
      end
      tick();
      vec_cnt++;
      if ({an, seg, frame} !== {4'b0001, 7'h7E, 1'b0}) begin
         err_cnt++;
         $display("FAIL midrst_e1: an=%b seg=%h frame=%b, expected an=0001 seg=7e frame=0",
                  an, seg, frame);
      end
      tick();
      vec_cnt++;
      if (an !== 4'b0001) begin
         err_cnt++;
         $display("FAIL midrst_e2: an=%b, expected 0001", an);
      end
      tick();
      vec_cnt++;
      if (an !== 4'b0010) begin
         err_cnt++;
         $display("FAIL midrst_e3: an=%b, expected 0010", an);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      din      = 16'h1234;
      blank_lz = 1'b0;
      load     = 1'b1;
      tick();                                   // edge 1
      load = 1'b0;
      for (int i = 0; i < 6; i++) tick();      // edges 2..7
      din  = 16'h5678;                          // load on the wrap edge
      load = 1'b1;
      tick();                                   // edge 8
      load = 1'b0;
      vec_cnt++;
      if ({an, seg, frame} !== {4'b1000, 7'h30, 1'b0}) begin
         err_cnt++;
         $display("FAIL wrapload_e8: an=%b seg=%h frame=%b, expected an=1000 seg=30 frame=0",
                  an, seg, frame);
      end
      tick();                                   // edge 9
      vec_cnt++;
      if ({an, seg, frame} !== {4'b0001, 7'h7F, 1'b1}) begin
         err_cnt++;
         $display("FAIL wrapload_e9: an=%b seg=%h frame=%b, expected an=0001 seg=7f frame=1",
                  an, seg, frame);
      end
      tick();                                   // edge 10
      din  = 16'h9ABC;
      load = 1'b1;
      tick();                                   // edge 11: shows 5678 digit 1
      vec_cnt++;
      if ({an, seg} !== {4'b0010, 7'h70}) begin
         err_cnt++;
         $display("FAIL b2b_e11: an=%b seg=%h, expected an=0010 seg=70", an, seg);
      end
      din = 16'hDEF0;
      tick();                                   // edge 12: shows 9ABC digit 1
      load = 1'b0;
      vec_cnt++;
      if ({an, seg} !== {4'b0010, 7'h1F}) begin
         err_cnt++;
         $display("FAIL b2b_e12: an=%b seg=%h, expected an=0010 seg=1f", an, seg);
      end
      tick();                                   // edge 13: shows DEF0 digit 2
      vec_cnt++;
      if ({an, seg} !== {4'b0100, 7'h4F}) begin
         err_cnt++;
         $display("FAIL b2b_e13: an=%b seg=%h, expected an=0100 seg=4f", an, seg);
      end
   endtask

`ifdef LED7SEG_SCAN_DP_EN
   task automatic test_dp();
      logic [3:0] an_seq [8];
      an_seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                 4'b0100, 4'b1000, 4'b1000, 4'b0001};
      do_reset();
      din      = 16'h1234;
      blank_lz = 1'b0;
      dp_in    = 4'b0100;
      load     = 1'b1;
      tick();                                   // edge 1
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         vec_cnt++;
         if ({an, dp} !== {an_seq[i], (i == 3 || i == 4)}) begin
            err_cnt++;
            $display("FAIL dp[%0d]: an=%b dp=%b, expected an=%b dp=%b",
                     i, an, dp, an_seq[i], (i == 3 || i == 4));
         end
      end
      do_reset();                               // val back to zero
      blank_lz = 1'b1;
      tick();                                   // edge 1
      for (int i = 0; i < 8; i++) begin
         tick();
         vec_cnt++;
         if ({an, dp} !== {an_seq[i], 1'b0}) begin
            err_cnt++;
            $display("FAIL dp_blank[%0d]: an=%b dp=%b, expected an=%b dp=0",
                     i, an, dp, an_seq[i]);
         end
      end
      dp_in    = 4'b0000;
      blank_lz = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_decode();
      test_blanking();
      test_midscan();
      test_back_to_back();
`ifdef LED7SEG_SCAN_DP_EN
      test_dp();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
